ssb_sync_supervisor: RTL and testbench

- Lock supervisor for the receiver front end. Consumes PSS detections, sample strobes and relative CFO estimates. Sequences the PSS detector between search-all and track-one-N_id_2 modes.
- Declares and maintains SSB lock by checking detections against an expected SSB period window. Accumulates CFO corrections into the absolute DDS phase increment.
- Sits between PSS detector outputs and the DDS/frame-sync configuration inputs.

---
 rtl/ssb_sync_supervisor.sv | 230 +++++++++++++++++++++++
 tb/tb_ssb_sync_supervisor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssb_sync_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : ssb_sync_supervisor
// Purpose  : SSB lock supervisor. It sequences the PSS detector between
//            search-all and track-one modes, and it declares or drops lock
//            from the timing of detections against the SSB period window.
//            It also integrates relative CFO estimates into an absolute DDS
//            phase increment.
// Options  : SSB_SYNC_SUPERVISOR_STATS_EN adds saturating statistics
//            outputs: detections, misses and lock losses.
// Revision : 1.0 - initial release
// ============================================================================
module ssb_sync_supervisor #(
   parameter int SSB_PERIOD  = 76800,
   parameter int WINDOW_TOL  = 16,
   parameter int CONFIRM_CNT = 2,
   parameter int MAX_MISS    = 3,
   parameter int CFO_DW      = 20
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              enable_i,
   input  logic              sample_valid_i,
   input  logic              N_id_2_valid_i,
   input  logic [1:0]        N_id_2_i,
   input  logic              CFO_valid_i,
   input  logic [CFO_DW-1:0] CFO_DDS_inc_i,
   output logic [1:0]        PSS_detector_mode_o,
   output logic [1:0]        requested_N_id_2_o,
   output logic [CFO_DW-1:0] CFO_DDS_inc_f_o,
   output logic              locked_o,
   output logic              lost_o,
   output logic [1:0]        state_o
`ifdef SSB_SYNC_SUPERVISOR_STATS_EN
   ,
   output logic [15:0]       det_count_o,
   output logic [15:0]       miss_count_total_o,
   output logic [7:0]        lost_count_o
`endif
);

   localparam int c_cnt_w  = $clog2(SSB_PERIOD + WINDOW_TOL + 1);
   localparam int c_hit_w  = $clog2(CONFIRM_CNT + 1);
   localparam int c_miss_w = $clog2(MAX_MISS + 1);

   localparam logic [c_cnt_w-1:0]  c_cnt_max  = c_cnt_w'(SSB_PERIOD + WINDOW_TOL);
   localparam logic [c_cnt_w-1:0]  c_win_lo   = c_cnt_w'(SSB_PERIOD - WINDOW_TOL);
   localparam logic [c_cnt_w-1:0]  c_tol      = c_cnt_w'(WINDOW_TOL);
   localparam logic [c_hit_w-1:0]  c_hit_last = c_hit_w'(CONFIRM_CNT - 1);
   localparam logic [c_miss_w-1:0] c_miss_last = c_miss_w'(MAX_MISS - 1);

   localparam logic [CFO_DW-1:0] c_cfo_max = {1'b0, {(CFO_DW-1){1'b1}}};
   localparam logic [CFO_DW-1:0] c_cfo_min = {1'b1, {(CFO_DW-1){1'b0}}};

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_search = 2'd1;
   localparam logic [1:0] c_st_cand   = 2'd2;
   localparam logic [1:0] c_st_locked = 2'd3;

   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [c_hit_w-1:0]  r_hit_cnt;
   logic [c_miss_w-1:0] r_miss_cnt;
   logic [1:0]          r_req;
   logic [CFO_DW-1:0]   r_cfo_acc;
   logic [1:0]          r_mode;
   logic                r_locked;
   logic                r_lost;
   logic [1:0]          w_mode_nxt;
   logic                w_locked_nxt;
   logic                w_lost_nxt;

   logic w_det_valid, w_det_match, w_in_win, w_timeout;
   logic w_srch_hit, w_cand_hit, w_lock_hit, w_lock_miss;
   logic [CFO_DW:0]   w_cfo_diff;
   logic [CFO_DW-1:0] w_cfo_sat;

   // N_id_2 = 3 is not a real cell identity, so such pulses never count
   assign w_det_valid = N_id_2_valid_i && (N_id_2_i != 2'd3);
   assign w_det_match = w_det_valid && (N_id_2_i == r_req);
   assign w_in_win    = (r_cnt >= c_win_lo);
   assign w_timeout   = (r_cnt == c_cnt_max);

   assign w_srch_hit  = (r_state == c_st_search) && w_det_valid;
   assign w_cand_hit  = (r_state == c_st_cand)   && w_det_match && w_in_win;
   assign w_lock_hit  = (r_state == c_st_locked) && w_det_match && w_in_win;
   // A detection landing on the timeout sample wins over the miss
   assign w_lock_miss = (r_state == c_st_locked) && w_timeout && !w_lock_hit;

   // CFO corrections are subtracted at one extra bit, then clamped
   assign w_cfo_diff = {r_cfo_acc[CFO_DW-1], r_cfo_acc}
                     - {CFO_DDS_inc_i[CFO_DW-1], CFO_DDS_inc_i};
   assign w_cfo_sat  = (w_cfo_diff[CFO_DW] != w_cfo_diff[CFO_DW-1])
                     ? (w_cfo_diff[CFO_DW] ? c_cfo_min : c_cfo_max)
                     : w_cfo_diff[CFO_DW-1:0];

   // State register
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) r_state <= c_st_idle;
      else           r_state <= w_state_nxt;
   end

   // Next-state decision; disable overrides every other condition
   always_comb begin
      w_state_nxt = r_state;
      if (!enable_i) begin
         w_state_nxt = c_st_idle;
      end else begin
         case (r_state)
            c_st_idle:   w_state_nxt = c_st_search;
            c_st_search: if (w_det_valid) w_state_nxt = c_st_cand;
            c_st_cand: begin
               if (w_det_valid && !w_det_match) begin
                  w_state_nxt = c_st_search;
               end else if (w_cand_hit) begin
                  if (r_hit_cnt == c_hit_last) w_state_nxt = c_st_locked;
               end else if (w_timeout) begin
                  w_state_nxt = c_st_search;
               end
            end
            default: begin
               if (w_lock_miss && (r_miss_cnt == c_miss_last)) w_state_nxt = c_st_search;
            end
         endcase
      end
   end

   // Output decode from the upcoming state so outputs track it with one cycle latency
   always_comb begin
      w_mode_nxt = 2'd1;
      case (w_state_nxt)
         c_st_idle:   w_mode_nxt = 2'd2;
         c_st_search: w_mode_nxt = 2'd0;
         default:     w_mode_nxt = 2'd1;
      endcase
      w_locked_nxt = (w_state_nxt == c_st_locked);
      w_lost_nxt   = (r_state == c_st_locked) && (w_state_nxt != c_st_locked);
   end

   // Output registers
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_mode   <= 2'd2;
         r_locked <= 1'b0;
         r_lost   <= 1'b0;
      end else begin
         r_mode   <= w_mode_nxt;
         r_locked <= w_locked_nxt;
         r_lost   <= w_lost_nxt;
      end
   end

   // Sample counter, hit/miss counters, tracked identity and CFO accumulator
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_cnt      <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_req      <= 2'd0;
         r_cfo_acc  <= '0;
      end else begin
         if (!enable_i || (r_state == c_st_idle)) begin
            r_cnt <= '0;
         end else if (w_srch_hit || w_cand_hit || w_lock_hit) begin
            r_cnt <= '0;
         end else if (w_lock_miss) begin
            // Reloading with the tolerance keeps the expected SSB grid free-running
            r_cnt <= c_tol;
         end else if (sample_valid_i && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end

         if (enable_i && w_srch_hit) begin
            r_req     <= N_id_2_i;
            r_hit_cnt <= '0;
         end else if (enable_i && w_cand_hit) begin
            r_hit_cnt <= r_hit_cnt + c_hit_w'(1);
         end

         if (enable_i && ((w_cand_hit && (r_hit_cnt == c_hit_last)) || w_lock_hit)) begin
            r_miss_cnt <= '0;
         end else if (enable_i && w_lock_miss) begin
            r_miss_cnt <= r_miss_cnt + c_miss_w'(1);
         end

         // The pre-transition state decides whether a CFO strobe applies
         if (CFO_valid_i && ((r_state == c_st_cand) || (r_state == c_st_locked))) begin
            r_cfo_acc <= w_cfo_sat;
         end else if ((r_state == c_st_idle) && enable_i) begin
            r_cfo_acc <= '0;
         end
      end
   end

`ifdef SSB_SYNC_SUPERVISOR_STATS_EN
   logic [15:0] r_det_count;
   logic [15:0] r_miss_total;
   logic [7:0]  r_lost_count;

   // Saturating statistics, cleared only by reset
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_det_count  <= '0;
         r_miss_total <= '0;
         r_lost_count <= '0;
      end else begin
         if (enable_i && (w_srch_hit || w_cand_hit || w_lock_hit) && (r_det_count != 16'hFFFF))
            r_det_count <= r_det_count + 16'd1;
         if (enable_i && w_lock_miss && (r_miss_total != 16'hFFFF))
            r_miss_total <= r_miss_total + 16'd1;
         if (w_lost_nxt && (r_lost_count != 8'hFF))
            r_lost_count <= r_lost_count + 8'd1;
      end
   end

   assign det_count_o        = r_det_count;
   assign miss_count_total_o = r_miss_total;
   assign lost_count_o       = r_lost_count;
`endif

   assign PSS_detector_mode_o = r_mode;
   assign requested_N_id_2_o  = r_req;
   assign CFO_DDS_inc_f_o     = r_cfo_acc;
   assign locked_o            = r_locked;
   assign lost_o              = r_lost;
   assign state_o             = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ssb_sync_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssb_sync_supervisor
// Purpose  : Directed self-checking bench for ssb_sync_supervisor, with a
//            behavioural reference model compared on every clock cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssb_sync_supervisor;

   localparam int P    = 100;
   localparam int T    = 4;
   localparam int CONF = 2;
   localparam int MAXM = 3;
   localparam int DW   = 20;

   logic          clk = 1'b0;
   logic          reset_ni = 1'b1;
   logic          enable = 1'b0;
   logic          sv = 1'b0;
   logic          dv = 1'b0;
   logic [1:0]    nid = 2'd0;
   logic          cv = 1'b0;
   logic [DW-1:0] cinc = '0;

   logic [1:0]    mode_o, req_o, state_o;
   logic [DW-1:0] cfo_o;
   logic          locked_o, lost_o;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_on = 1'b0;

   always #5 clk = ~clk;

   ssb_sync_supervisor #(
      .SSB_PERIOD(P), .WINDOW_TOL(T), .CONFIRM_CNT(CONF), .MAX_MISS(MAXM), .CFO_DW(DW)
   ) dut (
      .clk_i(clk),
      .reset_ni(reset_ni),
      .enable_i(enable),
      .sample_valid_i(sv),
      .N_id_2_valid_i(dv),
      .N_id_2_i(nid),
      .CFO_valid_i(cv),
      .CFO_DDS_inc_i(cinc),
      .PSS_detector_mode_o(mode_o),
      .requested_N_id_2_o(req_o),
      .CFO_DDS_inc_f_o(cfo_o),
      .locked_o(locked_o),
      .lost_o(lost_o),
      .state_o(state_o)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (spec-level) ----------------
   int     m_state, m_cnt, m_hit, m_miss, m_req;
   longint m_acc;
   bit     m_lost;

   task automatic m_reset();
      m_state = 0; m_cnt = 0; m_hit = 0; m_miss = 0; m_req = 0; m_acc = 0; m_lost = 0;
   endtask

   task automatic m_count();
      if (sv && m_cnt < P + T) m_cnt++;
   endtask

   task automatic model_step();
      bit det, inwin, tmo;
      int ns, inc;
      det   = dv && (nid != 2'd3);
      inwin = (m_cnt >= P - T);
      tmo   = (m_cnt == P + T);
      ns    = m_state;
      m_lost = 0;
      if (cv && (m_state == 2 || m_state == 3)) begin
         inc   = $signed(cinc);
         m_acc = m_acc - inc;
         if (m_acc > 2**(DW-1) - 1) m_acc = 2**(DW-1) - 1;
         if (m_acc < -(2**(DW-1)))  m_acc = -(2**(DW-1));
      end
      if (!enable) begin
         if (m_state == 3) m_lost = 1;
         ns = 0;
         m_cnt = 0;
      end else begin
         case (m_state)
            0: begin ns = 1; m_cnt = 0; m_acc = 0; end
            1: begin
               if (det) begin ns = 2; m_req = int'(nid); m_hit = 0; m_cnt = 0; end
               else m_count();
            end
            2: begin
               if (det && int'(nid) != m_req) begin ns = 1; m_count(); end
               else if (det && inwin) begin
                  m_hit++; m_cnt = 0;
                  if (m_hit == CONF) begin ns = 3; m_miss = 0; end
               end
               else if (tmo) begin ns = 1; m_count(); end
               else m_count();
            end
            default: begin
               if (det && int'(nid) == m_req && inwin) begin m_cnt = 0; m_miss = 0; end
               else if (tmo) begin
                  m_miss++; m_cnt = T;
                  if (m_miss == MAXM) begin ns = 1; m_lost = 1; end
               end
               else m_count();
            end
         endcase
      end
      m_state = ns;
   endtask

   always @(negedge reset_ni) m_reset();
   always @(posedge clk) if (reset_ni) model_step();

   // Per-cycle compare against the model
   always @(negedge clk) begin
      logic [DW-1:0] e_acc;
      int e_mode;
      if (cmp_on) begin
         e_acc  = DW'(m_acc);
         e_mode = (m_state == 0) ? 2 : (m_state == 1) ? 0 : 1;
         chk("m_state",  32'(state_o),  32'(m_state));
         chk("m_mode",   32'(mode_o),   32'(e_mode));
         chk("m_req",    32'(req_o),    32'(m_req));
         chk("m_cfo",    32'(cfo_o),    32'(e_acc));
         chk("m_locked", 32'(locked_o), 32'(m_state == 3));
         chk("m_lost",   32'(lost_o),   32'(m_lost));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(bit s, bit d, logic [1:0] n, bit c, logic [DW-1:0] ci);
      sv = s; dv = d; nid = n; cv = c; cinc = ci;
      @(negedge clk);
      sv = 1'b0; dv = 1'b0; nid = 2'd0; cv = 1'b0; cinc = '0;
   endtask

   task automatic samples(int k);
      repeat (k) cyc(1'b1, 1'b0, 2'd0, 1'b0, '0);
   endtask

   task automatic det(logic [1:0] n);
      cyc(1'b0, 1'b1, n, 1'b0, '0);
   endtask

   task automatic cfo(int v);
      cyc(1'b0, 1'b0, 2'd0, 1'b1, DW'(v));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lost_at, lost_n;
      m_reset();
      #1 reset_ni = 1'b0;
      repeat (3) @(negedge clk);
      cmp_on = 1'b1;
      chk("rst_state", 32'(state_o), 0);
      chk("rst_mode",  32'(mode_o), 2);
      chk("rst_cfo",   32'(cfo_o), 0);
      chk("rst_lock",  32'(locked_o), 0);
      chk("rst_lost",  32'(lost_o), 0);
      chk("rst_req",   32'(req_o), 0);
      reset_ni = 1'b1;

      // enable: IDLE -> SEARCH
      enable = 1'b1;
      cyc(1'b0, 1'b0, 2'd0, 1'b0, '0);
      chk("en_state", 32'(state_o), 1);
      chk("en_mode",  32'(mode_o), 0);
      chk("en_cfo",   32'(cfo_o), 0);
      chk("en_lock",  32'(locked_o), 0);

      // CFO in SEARCH is ignored
      cfo(5);
      chk("srch_cfo", 32'(cfo_o), 0);

      // Lock acquisition at samples 0, 100, 199
      det(2'd1);
      chk("acq1_state", 32'(state_o), 2);
      chk("acq1_mode",  32'(mode_o), 1);
      chk("acq1_req",   32'(req_o), 1);
      samples(100); det(2'd1);
      chk("acq2_state", 32'(state_o), 2);
      samples(99); det(2'd1);
      chk("acq3_state", 32'(state_o), 3);
      chk("acq3_lock",  32'(locked_o), 1);
      chk("acq3_req",   32'(req_o), 1);

      // CFO accumulation and saturation
      cfo(-524280);
      chk("cfo_load", 32'(cfo_o), 32'd524280);
      cfo(-100);
      chk("cfo_satp", 32'(cfo_o), 32'd524287);
      cfo(524287);
      chk("cfo_zero", 32'(cfo_o), 0);
      cfo(524287); cfo(10);
      chk("cfo_satn", 32'(cfo_o), 32'h80000);
      cfo(-524288);
      chk("cfo_back", 32'(cfo_o), 0);

      // One miss, then a detection exactly on the timeout sample
      samples(105);
      chk("miss1_lock", 32'(locked_o), 1);
      samples(100); det(2'd1);
      chk("tmo_det_state", 32'(state_o), 3);

      // Loss after three misses: free-running grid gives cycle 307
      lost_at = -1; lost_n = 0;
      for (int i = 1; i <= 320; i++) begin
         samples(1);
         if (lost_o) begin lost_n++; if (lost_at < 0) lost_at = i; end
      end
      chk("loss_cycle", 32'(lost_at), 307);
      chk("loss_pulses", 32'(lost_n), 1);
      chk("loss_state", 32'(state_o), 1);
      chk("loss_lock",  32'(locked_o), 0);

      // Mismatch in CANDIDATE
      det(2'd1); samples(100); det(2'd2);
      chk("mm_state", 32'(state_o), 1);
      chk("mm_mode",  32'(mode_o), 0);

      // Invalid detection ignored
      det(2'd3);
      chk("inv_state", 32'(state_o), 1);

      // Early matching detection ignored, then lock on N_id_2=0
      det(2'd0);
      chk("e_req", 32'(req_o), 0);
      samples(50); det(2'd0);
      chk("e_state", 32'(state_o), 2);
      samples(46); det(2'd0);
      samples(96); cyc(1'b1, 1'b1, 2'd0, 1'b0, '0);
      chk("e_lock", 32'(state_o), 3);
      det(2'd1);
      chk("lk_ign_mm", 32'(state_o), 3);

      // Disable while LOCKED, with a coincident CFO strobe
      enable = 1'b0;
      cfo(-3);
      chk("dis_state", 32'(state_o), 0);
      chk("dis_mode",  32'(mode_o), 2);
      chk("dis_lost",  32'(lost_o), 1);
      chk("dis_cfo",   32'(cfo_o), 3);
      cyc(1'b0, 1'b0, 2'd0, 1'b0, '0);
      chk("dis_lost2", 32'(lost_o), 0);
      enable = 1'b1;
      cyc(1'b0, 1'b0, 2'd0, 1'b0, '0);
      chk("reen_cfo", 32'(cfo_o), 0);

      // CANDIDATE timeout
      det(2'd2); samples(106);
      chk("ctmo_state", 32'(state_o), 1);

      // Async reset mid-LOCKED
      det(2'd2); samples(100); det(2'd2); samples(100); det(2'd2);
      chk("ar_pre", 32'(state_o), 3);
      cfo(-1000);
      @(posedge clk);
      #2 reset_ni = 1'b0;
      #1;
      chk("ar_state", 32'(state_o), 0);
      chk("ar_lock",  32'(locked_o), 0);
      chk("ar_mode",  32'(mode_o), 2);
      chk("ar_cfo",   32'(cfo_o), 0);
      chk("ar_req",   32'(req_o), 0);
      @(negedge clk);
      reset_ni = 1'b1;
      samples(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
